// File: rtl/cla_sched_pkg.sv
// Shared types for the CLA adder scheduler: datapath width, FSM states, adder result.
package cla_sched_pkg;

    localparam int DATA_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef struct packed {
        logic                  cout;
        logic [DATA_WIDTH-1:0] sum;
    } add_res_t;

endpackage

// File: rtl/carry_lookaheadadder_16bit.sv
// 16-bit carry-lookahead adder: four 4-bit groups with lookahead between groups.
// Purely combinational; no flow control.
module carry_lookaheadadder_16bit (
    input  logic [15:0] in_a,
    input  logic [15:0] in_b,
    input  logic        cin,
    output logic [15:0] out_data,
    output logic        cout
);

    logic [15:0] g;
    logic [15:0] p;
    logic [15:0] c;
    logic [3:0]  gg;
    logic [3:0]  gp;
    logic [4:0]  gc;

    always_comb begin
        g  = in_a & in_b;
        p  = in_a ^ in_b;
        gg = '0;
        gp = '0;
        gc = '0;
        c  = '0;
        gc[0] = cin;
        // Group generate/propagate feed the inter-group carry chain.
        for (int k = 0; k < 4; k++) begin
            gg[k] = g[4*k+3]
                  | (p[4*k+3] & g[4*k+2])
                  | (p[4*k+3] & p[4*k+2] & g[4*k+1])
                  | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
            gp[k] = &p[4*k +: 4];
            gc[k+1] = gg[k] | (gp[k] & gc[k]);
        end
        for (int k = 0; k < 4; k++) begin
            c[4*k] = gc[k];
            for (int j = 0; j < 3; j++) begin
                c[4*k+j+1] = g[4*k+j] | (p[4*k+j] & c[4*k+j]);
            end
        end
        out_data = p ^ c;
        cout     = gc[4];
    end

endmodule

// File: rtl/cla_adder_scheduler_rr_arbiter.sv
// Round-robin picker: first valid request at or above the pointer, wrapping; pointer
// moves past the winner only when the grant is taken (advance).
module rr_arbiter #(
    parameter  int N  = 4,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [N-1:0]  req,
    input  logic          advance,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_id,
    output logic          any
);

    logic [IW-1:0] ptr;

    always_comb begin
        int idx;
        idx      = 0;
        grant    = '0;
        grant_id = '0;
        any      = 1'b0;
        for (int i = 0; i < N; i++) begin
            idx = (int'(ptr) + i) % N;
            if (!any && req[idx]) begin
                any        = 1'b1;
                grant[idx] = 1'b1;
                grant_id   = IW'(idx);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (advance) begin
            ptr <= IW'((int'(grant_id) + 1) % N);
        end
    end

endmodule

// File: rtl/cla_adder_scheduler.sv
// Shares one 16-bit CLA among NUM_REQ requesters; 3-cycle op (accept, add, respond).
// Result held until rsp_ready; optional unsigned saturation under CLA_SCHED_SAT_EN.
module cla_adder_scheduler #(
    parameter  int NUM_REQ    = 4,
    parameter  int DATA_WIDTH = cla_sched_pkg::DATA_WIDTH,  // must stay 16: adder is fixed width
    localparam int ID_WIDTH   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_a,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_b,
    input  logic [NUM_REQ-1:0]            req_cin,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [ID_WIDTH-1:0]           rsp_id,
    output logic [DATA_WIDTH-1:0]         rsp_sum,
    output logic                          rsp_cout,
    output logic                          busy
);

    import cla_sched_pkg::*;

    state_t                state;
    state_t                state_nxt;
    logic [NUM_REQ-1:0]    grant;
    logic [ID_WIDTH-1:0]   grant_id;
    logic                  any_req;
    logic                  accept;
    logic [DATA_WIDTH-1:0] op_a;
    logic [DATA_WIDTH-1:0] op_b;
    logic                  op_cin;
    logic [ID_WIDTH-1:0]   op_id;
    add_res_t              add_res;
    logic [DATA_WIDTH-1:0] res_sum;

    rr_arbiter #(.N(NUM_REQ)) u_arb (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req_valid),
        .advance  (accept),
        .grant    (grant),
        .grant_id (grant_id),
        .any      (any_req)
    );

    assign accept    = (state == IDLE) && any_req;
    assign req_ready = (state == IDLE) ? grant : '0;
    assign busy      = (state != IDLE);

    carry_lookaheadadder_16bit u_cla (
        .in_a     (op_a),
        .in_b     (op_b),
        .cin      (op_cin),
        .out_data (add_res.sum),
        .cout     (add_res.cout)
    );

`ifdef CLA_SCHED_SAT_EN
    assign res_sum = add_res.cout ? {DATA_WIDTH{1'b1}} : add_res.sum;
`else
    assign res_sum = add_res.sum;
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_req) state_nxt = ADD;
            ADD:     state_nxt = RESP;
            RESP:    if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Operands are captured at the handshake so requesters may move on immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_a   <= '0;
            op_b   <= '0;
            op_cin <= 1'b0;
            op_id  <= '0;
        end else if (accept) begin
            op_a   <= req_a[grant_id*DATA_WIDTH +: DATA_WIDTH];
            op_b   <= req_b[grant_id*DATA_WIDTH +: DATA_WIDTH];
            op_cin <= req_cin[grant_id];
            op_id  <= grant_id;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_sum   <= '0;
            rsp_cout  <= 1'b0;
        end else if (state == ADD) begin
            rsp_valid <= 1'b1;
            rsp_id    <= op_id;
            rsp_sum   <= res_sum;
            rsp_cout  <= add_res.cout;
        end else if (state == RESP && rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

endmodule
